// File: rtl/hw4_pkg.sv
// hw4_pkg: shared state encoding and sizing helpers for the serial adder
package hw4_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  function automatic int cnt_w(int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/hw3p2.sv
// hw3p2: combinational one-bit full-adder cell
module hw3p2 (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/hw4_serial_adder.sv
// hw4_serial_adder: bit-serial a + b + cin, one full-adder cell, LSB first, start/done handshake
module hw4_serial_adder
  import hw4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, s, co, last;
  hw3p2 u_fa (.A(a_sh[0]), .B(b_sh[0]), .Cin(carry), .S(s), .Cout(co));
  assign last = cnt == CW'(WIDTH - 1);
  assign sum_nx = WIDTH'({s, sum_sh} >> 1);
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_comb begin
    next = IDLE;
    next = state == IDLE  ? (start ? SHIFT : IDLE) :
           state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        carry <= cin;
        cnt <= '0;
        sum_sh <= '0;
      end else if (state == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        sum_sh <= sum_nx;
        carry <= co;
        cnt <= cnt + 1'b1;
      end
      // carry still holds the carry into the MSB on the final bit
      if (state == SHIFT && last) begin
        sum <= sum_nx;
        cout <= co;
        ovf <= carry ^ co;
      end
    end
  end
endmodule

// File: tb/tb_hw4_serial_adder.sv
// tb_hw4_serial_adder: directed table plus handshake, back-to-back and reset sequences
module tb_hw4_serial_adder;
  logic clk = 0, rst_n = 1, start = 0, cin_i = 0;
  logic [3:0] a_i = 0, b_i = 0;
  logic busy, done, cout, ovf;
  logic [3:0] sum;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    string nm;
    logic [3:0] a, b;
    logic cin;
    logic [3:0] s;
    logic co, ov;
  } vec_t;
  vec_t tbl[6];

  hw4_serial_adder #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic ref_add(input logic [3:0] a, b, input logic cin,
                         output logic [3:0] s, output logic co, ov);
    logic [4:0] r;
    r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    s = r[3:0];
    co = r[4];
    ov = (a[3] == b[3]) && (r[3] != a[3]);
  endtask

  task automatic do_add(input logic [3:0] a, b, input logic cin, input bit hold,
                        output logic [3:0] s, output logic co, ov,
                        output int bc, output bit seen);
    @(negedge clk);
    a_i = a; b_i = b; cin_i = cin; start = 1;
    @(negedge clk);
    start = hold;
    bc = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) bc++;
        if (hold) begin a_i = ~a_i; b_i = b_i + 4'd3; cin_i = ~cin_i; end
        @(negedge clk);
      end
    end
    s = sum; co = cout; ov = ovf;
    chk("busy_done_excl", {31'b0, busy & done}, 0);
    start = 0;
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 0);
  endtask

  initial begin
    logic [3:0] s, es, na, nb;
    logic co, ov, eco, eov, nc;
    int bc, cyc, last_done, dn;
    bit seen;
    tbl[0] = '{"cout",    4'h6, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[1] = '{"cin",     4'h9, 4'hA, 1'b1, 4'h4, 1'b1, 1'b1};
    tbl[2] = '{"zero",    4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{"pos_ovf", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    tbl[4] = '{"wrap",    4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[5] = '{"neg_ovf", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};

    #1 rst_n = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sum", {28'b0, sum}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done || busy) dn++; end
    chk("idle_no_activity", dn, 0);

    foreach (tbl[i]) begin
      do_add(tbl[i].a, tbl[i].b, tbl[i].cin, 0, s, co, ov, bc, seen);
      chk({tbl[i].nm, "_seen"}, {31'b0, seen}, 1);
      chk({tbl[i].nm, "_busy_cycles"}, bc, 4);
      chk({tbl[i].nm, "_sum"}, {28'b0, s}, {28'b0, tbl[i].s});
      chk({tbl[i].nm, "_cout"}, {31'b0, co}, {31'b0, tbl[i].co});
      chk({tbl[i].nm, "_ovf"}, {31'b0, ov}, {31'b0, tbl[i].ov});
      chk({tbl[i].nm, "_hold_sum"}, {28'b0, sum}, {28'b0, tbl[i].s});
    end

    // start held through SHIFT and DONE with operands wiggling: must be ignored
    do_add(4'h5, 4'h3, 1'b0, 1, s, co, ov, bc, seen);
    chk("ign_seen", {31'b0, seen}, 1);
    chk("ign_busy_cycles", bc, 4);
    chk("ign_sum", {28'b0, s}, 4'h8);
    chk("ign_cout", {31'b0, co}, 0);
    chk("ign_ovf", {31'b0, ov}, 1);
    dn = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done || busy) dn++; end
    chk("ign_no_extra", dn, 0);
    chk("ign_hold_sum", {28'b0, sum}, 4'h8);

    // back-to-back with start held high
    @(negedge clk);
    a_i = 4'hF; b_i = 4'hF; cin_i = 1; start = 1;
    ref_add(a_i, b_i, cin_i, es, eco, eov);
    chk("ref_ff1_sum", {28'b0, es}, 4'hF);
    cyc = 0; last_done = -1;
    for (int k = 0; k < 201; k++) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk); cyc++;
        if (done) seen = 1;
      end
      chk("b2b_seen", {31'b0, seen}, 1);
      if (!seen) break;
      chk("b2b_sum", {28'b0, sum}, {28'b0, es});
      chk("b2b_cout", {31'b0, cout}, {31'b0, eco});
      chk("b2b_ovf", {31'b0, ovf}, {31'b0, eov});
      if (k > 0) chk("b2b_period", cyc - last_done, 6);
      last_done = cyc;
      na = 4'($urandom_range(0, 15)); nb = 4'($urandom_range(0, 15)); nc = 1'($urandom_range(0, 1));
      a_i = na; b_i = nb; cin_i = nc;
      ref_add(na, nb, nc, es, eco, eov);
    end
    start = 0;
    repeat (10) @(negedge clk);

    // aborted add: reset mid-SHIFT, then a clean add
    do_add(4'h8, 4'h8, 1'b0, 0, s, co, ov, bc, seen);
    chk("pre_abort_cout", {31'b0, cout}, 1);
    @(negedge clk);
    a_i = 4'hE; b_i = 4'hD; cin_i = 1; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_sum", {28'b0, sum}, 0);
    chk("abort_cout", {31'b0, cout}, 0);
    chk("abort_ovf", {31'b0, ovf}, 0);
    @(negedge clk);
    rst_n = 1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done || busy) dn++; end
    chk("abort_no_done", dn, 0);
    do_add(4'h3, 4'h4, 1'b1, 0, s, co, ov, bc, seen);
    chk("post_seen", {31'b0, seen}, 1);
    chk("post_busy_cycles", bc, 4);
    chk("post_sum", {28'b0, s}, 4'h8);
    chk("post_cout", {31'b0, co}, 0);
    chk("post_ovf", {31'b0, ov}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
